// File: rtl/sw_debounce_pkg.sv
// Shared constants and FSM state type for the slide-switch debounce block.
// Defaults target a 50 MHz clock with a 10 ms debounce window.
package sw_debounce_pkg;

   localparam int SW_WIDTH_DEFAULT = 10;
   localparam int CLK_HZ           = 50_000_000;
   localparam int DEBOUNCE_MS      = 10;
   localparam int CNT_MAX_DEFAULT  = (CLK_HZ / 1000) * DEBOUNCE_MS;

   typedef enum logic {
      DB_IDLE  = 1'b0,
      DB_COUNT = 1'b1
   } db_state_t;

endpackage

// File: rtl/debounce_bit.sv
// One switch bit: SYNC_STAGES-deep synchronizer followed by a two-state debounce FSM.
// Optional macro SW_DEBOUNCE_INIT_LOAD_EN loads the synchronized value once after reset.
module debounce_bit
   import sw_debounce_pkg::*;
#(
   parameter int CNT_MAX     = CNT_MAX_DEFAULT,
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic clean,
   output logic changed,
   output logic stable
);

   localparam int            CW       = $clog2(CNT_MAX);
   localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;
   logic                   mismatch;
   logic                   ready;
   logic                   init_load;
   logic                   accept;
   db_state_t              state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;

   always_ff @(posedge clk) begin
      if (rst) sync_q <= '0;
      else     sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
   end

   assign s        = sync_q[SYNC_STAGES-1];
   assign mismatch = s ^ clean;

`ifdef SW_DEBOUNCE_INIT_LOAD_EN
   localparam int FW = $clog2(SYNC_STAGES);

   logic [FW-1:0] fill_q;
   logic          init_done_q;

   assign ready     = init_done_q;
   assign init_load = !init_done_q && (fill_q == FW'(SYNC_STAGES - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         fill_q      <= '0;
         init_done_q <= 1'b0;
      end else if (!init_done_q) begin
         fill_q <= fill_q + 1'b1;
         if (init_load) init_done_q <= 1'b1;
      end
   end
`else
   assign ready     = 1'b1;
   assign init_load = 1'b0;
`endif

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) state_q <= DB_IDLE;
      else     state_q <= state_d;
   end

   // NOTE: defaults at the top of each combinational block prevent inferred latches.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         DB_IDLE:  if (ready && mismatch)              state_d = DB_COUNT;
         DB_COUNT: if (!mismatch || cnt_q == CNT_LAST) state_d = DB_IDLE;
         default:                                      state_d = DB_IDLE;
      endcase
   end

   always_comb begin
      accept = 1'b0;
      cnt_d  = '0;
      unique case (state_q)
         DB_IDLE: if (ready && mismatch) cnt_d = CW'(1);
         DB_COUNT: begin
            if (mismatch) begin
               if (cnt_q == CNT_LAST) accept = 1'b1;
               else                   cnt_d  = cnt_q + 1'b1;
            end
         end
         default: ;
      endcase
   end

   // The init load copies the stage feeding s, so clean and s agree right after it.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= '0;
         clean   <= 1'b0;
         changed <= 1'b0;
         stable  <= 1'b1;
      end else begin
         cnt_q   <= cnt_d;
         changed <= accept;
         stable  <= ready && (state_q == DB_IDLE) && !mismatch;
         if (init_load)   clean <= sync_q[SYNC_STAGES-2];
         else if (accept) clean <= s;
      end
   end

endmodule

// File: rtl/sw_debounce_sync.sv
// Slide-switch conditioning: WIDTH independent synchronize+debounce lanes with status strobes.
// Optional macro SW_DEBOUNCE_INIT_LOAD_EN mirrors power-up switch positions without a debounce delay.
module sw_debounce_sync
   import sw_debounce_pkg::*;
#(
   parameter int WIDTH       = SW_WIDTH_DEFAULT,
   parameter int CNT_MAX     = CNT_MAX_DEFAULT,
   parameter int SYNC_STAGES = 2
) (
   input  logic             MAX10_CLK1_50,
   input  logic             RESET,
   input  logic [WIDTH-1:0] SW_RAW,
   output logic [WIDTH-1:0] SW_CLEAN,
   output logic             SW_CHANGED,
   output logic             SW_STABLE
);

   logic [WIDTH-1:0] changed_bits;
   logic [WIDTH-1:0] stable_bits;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      debounce_bit #(
         .CNT_MAX     (CNT_MAX),
         .SYNC_STAGES (SYNC_STAGES)
      ) u_bit (
         .clk     (MAX10_CLK1_50),
         .rst     (RESET),
         .raw     (SW_RAW[i]),
         .clean   (SW_CLEAN[i]),
         .changed (changed_bits[i]),
         .stable  (stable_bits[i])
      );
   end

   // Reductions over per-lane flops, so simultaneous updates merge into one pulse.
   assign SW_CHANGED = |changed_bits;
   assign SW_STABLE  = &stable_bits;

endmodule

// File: tb/tb_sw_debounce_sync.sv
// Directed bench for sw_debounce_sync with CNT_MAX=4, SYNC_STAGES=2.
// Expectations follow the SW_DEBOUNCE_INIT_LOAD_EN setting of the build.
module tb_sw_debounce_sync;

   localparam int             WIDTH = 10;
   localparam logic [WIDTH-1:0] PAT = 10'b1110111011;
`ifdef SW_DEBOUNCE_INIT_LOAD_EN
   localparam bit INIT_LOAD = 1'b1;
`else
   localparam bit INIT_LOAD = 1'b0;
`endif

   logic             clk;
   logic             rst;
   logic [WIDTH-1:0] sw_raw;
   logic [WIDTH-1:0] sw_clean;
   logic             sw_changed;
   logic             sw_stable;

   int n_cmp = 0;
   int n_err = 0;

   sw_debounce_sync #(
      .WIDTH       (WIDTH),
      .CNT_MAX     (4),
      .SYNC_STAGES (2)
   ) dut (
      .MAX10_CLK1_50 (clk),
      .RESET         (rst),
      .SW_RAW        (sw_raw),
      .SW_CLEAN      (sw_clean),
      .SW_CHANGED    (sw_changed),
      .SW_STABLE     (sw_stable)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance n rising edges; inputs change and outputs are sampled 1 time unit later.
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset(input logic [WIDTH-1:0] v);
      rst    = 1'b1;
      sw_raw = v;
      tick(2);
      rst = 1'b0;
      tick(3);
   endtask

   task automatic test_reset;
      rst    = 1'b1;
      sw_raw = '0;
      tick(2);
      for (int k = 1; k <= 2; k++) begin
         tick(1);
         n_cmp++; if (sw_clean !== '0) begin n_err++; $display("FAIL reset_hold clean k=%0d: got %h want 000", k, sw_clean); end
         n_cmp++; if (sw_changed !== 1'b0) begin n_err++; $display("FAIL reset_hold changed k=%0d: got %b want 0", k, sw_changed); end
         n_cmp++; if (sw_stable !== 1'b1) begin n_err++; $display("FAIL reset_hold stable k=%0d: got %b want 1", k, sw_stable); end
      end
      rst = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         logic exp_stable;
         tick(1);
         exp_stable = !(INIT_LOAD && k <= 2);
         n_cmp++; if (sw_clean !== '0) begin n_err++; $display("FAIL reset_idle clean k=%0d: got %h want 000", k, sw_clean); end
         n_cmp++; if (sw_changed !== 1'b0) begin n_err++; $display("FAIL reset_idle changed k=%0d: got %b want 0", k, sw_changed); end
         n_cmp++; if (sw_stable !== exp_stable) begin n_err++; $display("FAIL reset_idle stable k=%0d: got %b want %b", k, sw_stable, exp_stable); end
      end
   endtask

   task automatic test_step;
      do_reset('0);
      for (int k = 1; k <= 9; k++) begin
         logic [WIDTH-1:0] exp_clean;
         logic             exp_changed, exp_stable;
         sw_raw = PAT;
         tick(1);
         exp_clean   = (k >= 6) ? PAT : '0;
         exp_changed = (k == 6);
         exp_stable  = !(k >= 3 && k <= 6);
         n_cmp++; if (sw_clean !== exp_clean) begin n_err++; $display("FAIL step clean k=%0d: got %h want %h", k, sw_clean, exp_clean); end
         n_cmp++; if (sw_changed !== exp_changed) begin n_err++; $display("FAIL step changed k=%0d: got %b want %b", k, sw_changed, exp_changed); end
         n_cmp++; if (sw_stable !== exp_stable) begin n_err++; $display("FAIL step stable k=%0d: got %b want %b", k, sw_stable, exp_stable); end
      end
   endtask

   // Three-cycle pulse is one short of the accept threshold.
   task automatic test_glitch;
      do_reset('0);
      for (int k = 1; k <= 10; k++) begin
         logic exp_stable;
         sw_raw = {{(WIDTH-1){1'b0}}, (k <= 3)};
         tick(1);
         exp_stable = !(k >= 3 && k <= 6);
         n_cmp++; if (sw_clean !== '0) begin n_err++; $display("FAIL glitch clean k=%0d: got %h want 000", k, sw_clean); end
         n_cmp++; if (sw_changed !== 1'b0) begin n_err++; $display("FAIL glitch changed k=%0d: got %b want 0", k, sw_changed); end
         n_cmp++; if (sw_stable !== exp_stable) begin n_err++; $display("FAIL glitch stable k=%0d: got %b want %b", k, sw_stable, exp_stable); end
      end
   endtask

   // Four-cycle pulse is exactly CNT_MAX long: accepted, then debounced back to 0.
   task automatic test_min_pulse;
      do_reset('0);
      for (int k = 1; k <= 12; k++) begin
         logic [WIDTH-1:0] exp_clean;
         logic             exp_changed, exp_stable;
         sw_raw = {{(WIDTH-1){1'b0}}, (k <= 4)};
         tick(1);
         exp_clean   = {{(WIDTH-1){1'b0}}, (k >= 6 && k <= 9)};
         exp_changed = (k == 6) || (k == 10);
         exp_stable  = !(k >= 3 && k <= 10);
         n_cmp++; if (sw_clean !== exp_clean) begin n_err++; $display("FAIL min_pulse clean k=%0d: got %h want %h", k, sw_clean, exp_clean); end
         n_cmp++; if (sw_changed !== exp_changed) begin n_err++; $display("FAIL min_pulse changed k=%0d: got %b want %b", k, sw_changed, exp_changed); end
         n_cmp++; if (sw_stable !== exp_stable) begin n_err++; $display("FAIL min_pulse stable k=%0d: got %b want %b", k, sw_stable, exp_stable); end
      end
   endtask

   task automatic test_back_to_back;
      logic [WIDTH-1:0] nxt;
      do_reset('0);
      sw_raw = PAT;
      tick(8);
      nxt = PAT ^ 10'b0010001000;
      for (int k = 1; k <= 9; k++) begin
         logic [WIDTH-1:0] exp_clean;
         logic             exp_changed, exp_stable;
         sw_raw = nxt;
         tick(1);
         exp_clean   = (k >= 6) ? nxt : PAT;
         exp_changed = (k == 6);
         exp_stable  = !(k >= 3 && k <= 6);
         n_cmp++; if (sw_clean !== exp_clean) begin n_err++; $display("FAIL simul clean k=%0d: got %h want %h", k, sw_clean, exp_clean); end
         n_cmp++; if (sw_changed !== exp_changed) begin n_err++; $display("FAIL simul changed k=%0d: got %b want %b", k, sw_changed, exp_changed); end
         n_cmp++; if (sw_stable !== exp_stable) begin n_err++; $display("FAIL simul stable k=%0d: got %b want %b", k, sw_stable, exp_stable); end
      end
   endtask

   task automatic test_reset_mid;
      int acc_k;
      do_reset('0);
      sw_raw = 10'b0000100000;
      tick(4);
      rst = 1'b1;
      for (int k = 1; k <= 2; k++) begin
         tick(1);
         n_cmp++; if (sw_clean !== '0) begin n_err++; $display("FAIL mid_reset clean k=%0d: got %h want 000", k, sw_clean); end
         n_cmp++; if (sw_stable !== 1'b1) begin n_err++; $display("FAIL mid_reset stable k=%0d: got %b want 1", k, sw_stable); end
      end
      rst   = 1'b0;
      acc_k = INIT_LOAD ? 2 : 6;
      for (int k = 1; k <= 8; k++) begin
         logic [WIDTH-1:0] exp_clean;
         logic             exp_changed;
         tick(1);
         exp_clean   = (k >= acc_k) ? 10'b0000100000 : '0;
         exp_changed = !INIT_LOAD && (k == 6);
         n_cmp++; if (sw_clean !== exp_clean) begin n_err++; $display("FAIL mid_reaccept clean k=%0d: got %h want %h", k, sw_clean, exp_clean); end
         n_cmp++; if (sw_changed !== exp_changed) begin n_err++; $display("FAIL mid_reaccept changed k=%0d: got %b want %b", k, sw_changed, exp_changed); end
      end
   endtask

   task automatic test_power_up;
      rst    = 1'b1;
      sw_raw = 10'h3FF;
      tick(3);
      rst = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         logic [WIDTH-1:0] exp_clean;
         logic             exp_changed, exp_stable;
         tick(1);
         exp_clean   = (k >= (INIT_LOAD ? 2 : 6)) ? 10'h3FF : '0;
         exp_changed = !INIT_LOAD && (k == 6);
         exp_stable  = INIT_LOAD ? (k >= 3) : !(k >= 3 && k <= 6);
         n_cmp++; if (sw_clean !== exp_clean) begin n_err++; $display("FAIL power_up clean k=%0d: got %h want %h", k, sw_clean, exp_clean); end
         n_cmp++; if (sw_changed !== exp_changed) begin n_err++; $display("FAIL power_up changed k=%0d: got %b want %b", k, sw_changed, exp_changed); end
         n_cmp++; if (sw_stable !== exp_stable) begin n_err++; $display("FAIL power_up stable k=%0d: got %b want %b", k, sw_stable, exp_stable); end
      end
   endtask

   initial begin
      rst    = 1'b1;
      sw_raw = '0;
      test_reset();
      test_step();
      test_glitch();
      test_min_pulse();
      test_back_to_back();
      test_reset_mid();
      test_power_up();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
